dmem_arbiter: RTL and testbench

//  Shares the single-port Data_Memory of pipelined_mips between two requesters.
//  - CPU MEM stage: single-word accesses, stalls the pipeline while waiting.
//  - AES engine: atomic BURST_LEN-word bursts, i.e. one 128-bit state/key block.
//  - Sits between the MEM stage, the AES core and the Data_Memory port.
//  - Fixed CPU priority, with an anti-starvation override for AES.

---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU MEM-stage port, the AES burst port and the Data_Memory port
// seen by dmem_arbiter. The arbiter uses the slave view, its environment the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
);
  localparam int BW = $clog2(BURST_LEN);

  // Handshake: a requester raises *_req with its fields and holds them until the
  // single-cycle *_done pulse; dropping it afterwards ends the transaction. Memory
  // accepts an access every cycle mem_en=1 and returns read data one cycle later.
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_stall;

  logic              aes_req;
  logic              aes_we;
  logic [ADDR_W-1:0] aes_addr;
  logic [DATA_W-1:0] aes_wdata;
  logic              aes_beat;
  logic [BW-1:0]     aes_beat_idx;
  logic              aes_rvalid;
  logic [BW-1:0]     aes_ridx;
  logic [DATA_W-1:0] aes_rdata;
  logic              aes_done;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_stall,
    input  aes_req, aes_we, aes_addr, aes_wdata,
    output aes_beat, aes_beat_idx, aes_rvalid, aes_ridx, aes_rdata, aes_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_stall,
    output aes_req, aes_we, aes_addr, aes_wdata,
    input  aes_beat, aes_beat_idx, aes_rvalid, aes_ridx, aes_rdata, aes_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port Data_Memory between the CPU MEM stage (single words)
// and the AES engine (atomic bursts); CPU has priority unless AES has waited too long.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BURST_LEN    = 4,
  parameter int AES_MAX_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  dmem_arbiter_if.slave bus,
  output logic [2:0] dbg_state,
  output logic [7:0] dbg_wait_cnt,
  output logic       dbg_starve
);
  localparam int BW  = $clog2(BURST_LEN);
  localparam int WCW = $clog2(AES_MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPU_ISSUE = 3'd1,
    CPU_RESP  = 3'd2,
    AES_BURST = 3'd3,
    AES_DRAIN = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [BW-1:0]     beat;
  logic [WCW-1:0]    wait_cnt;
  logic              starve;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              rvalid_q;
  logic [BW-1:0]     ridx_q;
  logic              cpu_grant;
  logic              aes_grant;
  logic              aes_busy;

  assign starve    = (wait_cnt == WCW'(AES_MAX_WAIT));
  assign cpu_grant = (state == IDLE) && bus.cpu_req && !(bus.aes_req && starve);
  assign aes_grant = (state == IDLE) && !cpu_grant && bus.aes_req;
  assign aes_busy  = (state == AES_BURST) || (state == AES_DRAIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cpu_grant)      state_nxt = CPU_ISSUE;
        else if (aes_grant) state_nxt = AES_BURST;
      end
      CPU_ISSUE: state_nxt = CPU_RESP;
      CPU_RESP:  state_nxt = IDLE;
      AES_BURST: if (beat == BW'(BURST_LEN - 1)) state_nxt = AES_DRAIN;
      AES_DRAIN: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      beat      <= '0;
      wait_cnt  <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rvalid_q  <= 1'b0;
      ridx_q    <= '0;
    end else begin
      state <= state_nxt;
      if (cpu_grant) begin
        lat_we    <= bus.cpu_we;
        lat_addr  <= bus.cpu_addr;
        lat_wdata <= bus.cpu_wdata;
      end else if (aes_grant) begin
        lat_we    <= bus.aes_we;
        lat_addr  <= bus.aes_addr & ~ADDR_W'(3);
        lat_wdata <= '0;
      end
      // BURST_LEN is a power of two, so the beat counter wraps back to 0 on the last beat.
      beat     <= (state == AES_BURST) ? beat + BW'(1) : '0;
      rvalid_q <= (state == AES_BURST) && !lat_we;
      ridx_q   <= (state == AES_BURST) ? beat : '0;
      if (aes_grant)
        wait_cnt <= '0;
      else if (bus.aes_req && !aes_busy && !starve)
        wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // Memory port comes only from state and latched fields; write data of a burst
  // streams straight from the AES engine so it can present one word per beat.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.aes_beat  = 1'b0;
    case (state)
      CPU_ISSUE: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = lat_we;
        bus.mem_addr  = lat_addr;
        bus.mem_wdata = lat_wdata;
      end
      AES_BURST: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = lat_we;
        bus.mem_addr  = lat_addr + ADDR_W'({beat, 2'b00});
        bus.mem_wdata = bus.aes_wdata;
        bus.aes_beat  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.cpu_done     = (state == CPU_RESP);
  assign bus.cpu_rdata    = bus.cpu_done ? bus.mem_rdata : '0;
  assign bus.cpu_stall    = rst && bus.cpu_req && !bus.cpu_done;
  assign bus.aes_beat_idx = beat;
  assign bus.aes_rvalid   = rvalid_q;
  assign bus.aes_ridx     = ridx_q;
  assign bus.aes_rdata    = rvalid_q ? bus.mem_rdata : '0;
  assign bus.aes_done     = (state == AES_DRAIN);

  assign dbg_state    = state;
  assign dbg_wait_cnt = 8'(wait_cnt);
  assign dbg_starve   = starve;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural sync-read memory, CPU/AES driver tasks and
// per-scenario tasks comparing against bench-computed expectations.
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BURST_LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  logic [7:0] dbg_wait_cnt;
  logic       dbg_starve;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [1:0]  exp_idx_q[$];
  logic [31:0] obs_data_q[$];
  logic [31:0] obs_addr_q[$];
  logic [1:0]  obs_idx_q[$];
  int          bad_we;
  logic [7:0]  first_beat_wait;

  logic [31:0] mem_model [logic [31:0]];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .AES_MAX_WAIT(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state),
    .dbg_wait_cnt(dbg_wait_cnt),
    .dbg_starve(dbg_starve)
  );

  // Single-port synchronous memory
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
      else bus.mem_rdata <= mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : 32'h0;
    end
  end

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  task automatic clear_obs();
    obs_data_q.delete(); obs_addr_q.delete(); obs_idx_q.delete();
    exp_q.delete(); exp_addr_q.delete(); exp_idx_q.delete();
    bad_we = 0;
    first_beat_wait = 8'hFF;
  endtask

  // Drives one CPU access from the current negedge; cycle 0 is the request cycle.
  task automatic do_cpu(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int done_cyc, output logic [31:0] rdata);
    int cyc = 0;
    done_cyc = -1;
    rdata = '0;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    while (cyc < 100 && done_cyc < 0) begin
      #1;
      if (bus.cpu_done) begin done_cyc = cyc; rdata = bus.cpu_rdata; end
      @(negedge clk);
      cyc++;
    end
    bus.cpu_req = 1'b0;
  endtask

  // Drives one AES burst from the current negedge and records what it observes.
  task automatic do_aes(input logic we, input logic [31:0] base, input logic [127:0] wd,
                        output int start_cyc, output int done_cyc, output int nbeats);
    int cyc = 0;
    start_cyc = -1; done_cyc = -1; nbeats = 0;
    bus.aes_req = 1'b1; bus.aes_we = we; bus.aes_addr = base; bus.aes_wdata = wd[31:0];
    while (cyc < 100 && done_cyc < 0) begin
      if (bus.aes_beat) begin
        if (start_cyc < 0) begin start_cyc = cyc; first_beat_wait = dbg_wait_cnt; end
        bus.aes_wdata = wd[int'(bus.aes_beat_idx)*32 +: 32];
      end
      #1;
      if (bus.aes_beat) begin
        nbeats++;
        obs_addr_q.push_back(bus.mem_addr);
        if (bus.mem_we !== we) bad_we++;
        if (we) obs_data_q.push_back(bus.mem_wdata);
      end
      if (bus.aes_rvalid) begin
        obs_data_q.push_back(bus.aes_rdata);
        obs_idx_q.push_back(bus.aes_ridx);
      end
      if (bus.aes_done) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    bus.aes_req = 1'b0;
  endtask

  task automatic check_burst(input string name);
    logic [31:0] e, ea, od, oa;
    logic [1:0] ei, oi;
    checks++;
    if (bad_we != 0) begin
      failures++; $display("FAIL %s_we: %0d beats with wrong mem_we, required 0", name, bad_we);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ea = exp_addr_q.pop_front();
      checks++;
      if (obs_data_q.size() == 0 || obs_addr_q.size() == 0) begin
        failures++; $display("FAIL %s_beat: missing beat, required addr=%h data=%h", name, ea, e);
      end else begin
        od = obs_data_q.pop_front(); oa = obs_addr_q.pop_front();
        if (od !== e || oa !== ea) begin
          failures++; $display("FAIL %s_beat: got addr=%h data=%h, required addr=%h data=%h", name, oa, od, ea, e);
        end
      end
    end
    while (exp_idx_q.size() > 0) begin
      ei = exp_idx_q.pop_front();
      checks++;
      oi = (obs_idx_q.size() > 0) ? obs_idx_q.pop_front() : 2'bxx;
      if (oi !== ei) begin
        failures++; $display("FAIL %s_ridx: got %0d, required %0d", name, oi, ei);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.cpu_req = 1'b1; bus.aes_req = 1'b1; bus.aes_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.mem_en, bus.mem_we, bus.cpu_done, bus.cpu_stall, bus.aes_beat, bus.aes_rvalid, bus.aes_done} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b, required 0000000",
        {bus.mem_en, bus.mem_we, bus.cpu_done, bus.cpu_stall, bus.aes_beat, bus.aes_rvalid, bus.aes_done});
    end
    checks++;
    if (bus.mem_addr !== 0 || bus.mem_wdata !== 0 || bus.cpu_rdata !== 0 || bus.aes_rdata !== 0) begin
      failures++; $display("FAIL reset_data: addr=%h wdata=%h cpu_rdata=%h aes_rdata=%h, required all 0",
        bus.mem_addr, bus.mem_wdata, bus.cpu_rdata, bus.aes_rdata);
    end
    checks++;
    if (dbg_state !== 3'd0 || dbg_wait_cnt !== 8'd0 || bus.aes_beat_idx !== 2'd0) begin
      failures++; $display("FAIL reset_state: state=%0d wait=%0d idx=%0d, required 0 0 0", dbg_state, dbg_wait_cnt, bus.aes_beat_idx);
    end
    bus.cpu_req = 1'b0; bus.aes_req = 1'b0; bus.aes_wdata = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    logic [31:0] e;
    mem_model[32'h14] = 32'h5;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h14; bus.cpu_wdata = 32'h0;
    exp_q.push_back(32'h5);
    #1;
    checks++;
    if (bus.cpu_stall !== 1'b1 || bus.mem_en !== 1'b0) begin
      failures++; $display("FAIL cpu_rd_c0: stall=%b mem_en=%b, required 1 0", bus.cpu_stall, bus.mem_en);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h14 || bus.cpu_stall !== 1'b1 || bus.cpu_done !== 1'b0) begin
      failures++; $display("FAIL cpu_rd_c1: en=%b we=%b addr=%h stall=%b done=%b, required 1 0 00000014 1 0",
        bus.mem_en, bus.mem_we, bus.mem_addr, bus.cpu_stall, bus.cpu_done);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.cpu_done !== 1'b1 || bus.cpu_rdata !== e || bus.cpu_stall !== 1'b0 || bus.mem_en !== 1'b0) begin
      failures++; $display("FAIL cpu_rd_c2: done=%b rdata=%h stall=%b en=%b, required 1 %h 0 0",
        bus.cpu_done, bus.cpu_rdata, bus.cpu_stall, bus.mem_en, e);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_done !== 1'b0 || dbg_state !== 3'd0) begin
      failures++; $display("FAIL cpu_rd_c3: done=%b state=%0d, required 0 0", bus.cpu_done, dbg_state);
    end
  endtask

  task automatic test_cpu_write();
    int dc;
    logic [31:0] rd;
    do_cpu(1'b1, 32'h30, 32'h77, dc, rd);
    checks++;
    if (dc !== 2) begin
      failures++; $display("FAIL cpu_wr_latency: done at %0d, required 2", dc);
    end
    checks++;
    if (mem_peek(32'h30) !== 32'h77) begin
      failures++; $display("FAIL cpu_wr_mem: got %h, required 00000077", mem_peek(32'h30));
    end
  endtask

  task automatic test_aes_write();
    int s, d, n;
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back(32'h20 + 4 * k);
      exp_q.push_back(32'hA0 + k);
    end
    do_aes(1'b1, 32'h23, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, s, d, n);
    checks++;
    if (s !== 1 || d !== 5 || n !== 4) begin
      failures++; $display("FAIL aes_wr_timing: start=%0d done=%0d beats=%0d, required 1 5 4", s, d, n);
    end
    check_burst("aes_wr");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_peek(32'h20 + 4 * k) !== 32'hA0 + k) begin
        failures++; $display("FAIL aes_wr_mem: addr %h got %h, required %h", 32'h20 + 4 * k, mem_peek(32'h20 + 4 * k), 32'hA0 + k);
      end
    end
  endtask

  task automatic test_simultaneous();
    int cd, s, d, n;
    logic [31:0] rd;
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back(32'h20 + 4 * k);
      exp_q.push_back(32'hA0 + k);
      exp_idx_q.push_back(2'(k));
    end
    fork
      do_cpu(1'b0, 32'h14, 32'h0, cd, rd);
      do_aes(1'b0, 32'h20, 128'h0, s, d, n);
    join
    checks++;
    if (cd !== 2 || rd !== 32'h5) begin
      failures++; $display("FAIL sim_cpu: done at %0d rdata=%h, required 2 00000005", cd, rd);
    end
    checks++;
    if (s !== 4 || d !== 8) begin
      failures++; $display("FAIL sim_aes: start=%0d done=%0d, required 4 8", s, d);
    end
    check_burst("sim_aes");
  endtask

  task automatic test_starvation();
    int s, d, n, ndone;
    ndone = 0;
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      exp_addr_q.push_back(32'h60 + 4 * k);
      exp_q.push_back(32'hC0 + k);
    end
    fork
      begin
        int c = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h14;
        while (c < 80 && ndone < 4) begin
          #1;
          if (bus.cpu_done) ndone++;
          @(negedge clk);
          c++;
        end
        bus.cpu_req = 1'b0;
      end
      do_aes(1'b1, 32'h60, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, s, d, n);
    join
    checks++;
    if (s <= 1 || s > 10) begin
      failures++; $display("FAIL starve_grant: burst started at %0d, required 2..10", s);
    end
    checks++;
    if (first_beat_wait !== 8'd0) begin
      failures++; $display("FAIL starve_clear: wait counter %0d at first beat, required 0", first_beat_wait);
    end
    checks++;
    if (ndone !== 4) begin
      failures++; $display("FAIL starve_cpu: %0d cpu accesses, required 4", ndone);
    end
    @(negedge clk);
    checks++;
    if (dbg_wait_cnt !== 8'd0 || dbg_starve !== 1'b0) begin
      failures++; $display("FAIL starve_after: wait=%0d starve=%b, required 0 0", dbg_wait_cnt, dbg_starve);
    end
    check_burst("starve_aes");
  endtask

  task automatic test_aes_read_wrap();
    int s, d, n;
    logic [31:0] addrs [4];
    addrs[0] = 32'hFFFF_FFF8; addrs[1] = 32'hFFFF_FFFC; addrs[2] = 32'h0; addrs[3] = 32'h4;
    clear_obs();
    for (int k = 0; k < 4; k++) begin
      mem_model[addrs[k]] = 32'h1100 + k;
      exp_addr_q.push_back(addrs[k]);
      exp_q.push_back(32'h1100 + k);
      exp_idx_q.push_back(2'(k));
    end
    do_aes(1'b0, 32'hFFFF_FFF8, 128'h0, s, d, n);
    checks++;
    if (s !== 1 || d !== 5 || n !== 4) begin
      failures++; $display("FAIL wrap_timing: start=%0d done=%0d beats=%0d, required 1 5 4", s, d, n);
    end
    check_burst("wrap_rd");
  endtask

  task automatic test_reset_mid_burst();
    int cyc = 0;
    int ndone = 0;
    logic seen = 1'b0;
    for (int k = 0; k < 4; k++) mem_model[32'h80 + 4 * k] = 32'hDEAD_0000 + k;
    bus.aes_req = 1'b1; bus.aes_we = 1'b1; bus.aes_addr = 32'h80; bus.aes_wdata = 32'hB0;
    while (cyc < 20 && !seen) begin
      if (bus.aes_beat) bus.aes_wdata = 32'hB0 + 32'(bus.aes_beat_idx);
      if (bus.aes_beat && bus.aes_beat_idx == 2'd1) seen = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    checks++;
    if (!seen) begin
      failures++; $display("FAIL rst_mid_beat1: second beat not reached in 20 cycles, required reached");
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_en !== 1'b0 || bus.aes_beat !== 1'b0 || dbg_state !== 3'd0) begin
      failures++; $display("FAIL rst_mid_now: en=%b beat=%b state=%0d, required 0 0 0", bus.mem_en, bus.aes_beat, dbg_state);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (bus.aes_done) ndone++;
    end
    bus.aes_req = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      if (bus.aes_done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++; $display("FAIL rst_mid_done: %0d aes_done pulses, required 0", ndone);
    end
    checks++;
    if (mem_peek(32'h80) !== 32'hB0 || mem_peek(32'h84) !== 32'hDEAD_0001) begin
      failures++; $display("FAIL rst_mid_mem: [80]=%h [84]=%h, required 000000b0 dead0001", mem_peek(32'h80), mem_peek(32'h84));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.aes_req = 1'b0; bus.aes_we = 1'b0; bus.aes_addr = '0; bus.aes_wdata = '0;
    bus.mem_rdata = '0;
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_aes_write();
    test_simultaneous();
    test_starvation();
    test_aes_read_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
